traffic_light_intersection: RTL and testbench

Parametrised N-direction intersection controller, the successor to the single-approach red/yellow/green FSM. It serves car requests round-robin and times each phase with a shared tick prescaler. An emergency pre-emption input forces all-red. It sits between sensor inputs and lamp drivers, one instance per intersection.

---
 rtl/traffic_light_intersection_pkg.sv | 30 +++
 rtl/tl_rr_arbiter.sv | 35 +++
 rtl/traffic_light_intersection.sv | 148 ++++++++++++++
 tb/tb_traffic_light_intersection.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_intersection_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared state encoding and sizing helper for the
//                N-direction traffic light intersection controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    TL_IDLE   = 3'd0,
    TL_GREEN  = 3'd1,
    TL_YELLOW = 3'd2,
    TL_CLEAR  = 3'd3,
    TL_EMERG  = 3'd4
  } tl_state_e;

  // Timer must hold the largest (duration - 1) value; one spare bit keeps
  // the width non-zero for single-tick durations.
  function automatic int timer_width(input int g_ticks, input int y_ticks,
                                     input int c_ticks);
    int m;
    m = g_ticks;
    if (y_ticks > m) m = y_ticks;
    if (c_ticks > m) m = c_ticks;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tl_rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request bit found searching upward from last_served+1,
//                wrapping modulo N_DIR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_rr_arbiter #(
  parameter int N_DIR = 4
) (
  input  logic [N_DIR-1:0]         request,
  input  logic [$clog2(N_DIR)-1:0] last_served,
  output logic                     valid,
  output logic [$clog2(N_DIR)-1:0] grant_idx
);

  localparam int DIR_W = $clog2(N_DIR);

  // Scan from the farthest offset down to the nearest so the closest
  // requester after last_served is the final (winning) assignment.
  always_comb begin
    valid     = |request;
    grant_idx = '0;
    for (int k = N_DIR; k >= 1; k--) begin
      int               idx;
      logic [DIR_W-1:0] sel;
      idx = (int'(last_served) + k) % N_DIR;
      sel = DIR_W'(idx);
      if (request[sel]) grant_idx = sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_intersection.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_intersection
//  Description : N-direction intersection controller. Serves latched car
//                requests round-robin through GREEN/YELLOW/CLEAR phases timed
//                by a shared tick prescaler; emergency pre-empts to all-red.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_intersection
  import traffic_pkg::*;
#(
  parameter int N_DIR        = 4,
  parameter int TICK_DIV     = 1,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int CLEAR_TICKS  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_DIR-1:0]         car,
  input  logic                     emergency,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic [$clog2(N_DIR)-1:0] active_dir
);

  localparam int DIR_W = $clog2(N_DIR);
  localparam int TMR_W = timer_width(GREEN_TICKS, YELLOW_TICKS, CLEAR_TICKS);
  localparam int PS_W  = $clog2(TICK_DIV) + 1;

  if (N_DIR < 2) begin : g_chk_n_dir
    $error("N_DIR must be >= 2");
  end
  if (TICK_DIV < 1) begin : g_chk_tick_div
    $error("TICK_DIV must be >= 1");
  end
  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || CLEAR_TICKS < 1) begin : g_chk_ticks
    $error("phase durations must be >= 1 tick");
  end

  tl_state_e        state, state_next;
  logic [N_DIR-1:0] pending;
  logic [DIR_W-1:0] last_served;
  logic [TMR_W-1:0] timer, timer_load;
  logic [PS_W-1:0]  prescaler;
  logic             tick, expired, take_grant;
  logic             arb_valid;
  logic [DIR_W-1:0] arb_grant;

  // Fresh car inputs count immediately so IDLE reacts within one edge.
  tl_rr_arbiter #(.N_DIR(N_DIR)) u_arb (
    .request     (pending | car),
    .last_served (last_served),
    .valid       (arb_valid),
    .grant_idx   (arb_grant)
  );

  assign tick    = (prescaler == PS_W'(TICK_DIV - 1));
  assign expired = tick && (timer == '0);

  // Next-state selection plus Moore lamp decode from registered state.
  always_comb begin
    state_next = state;
    take_grant = 1'b0;
    green      = '0;
    yellow     = '0;
    case (state)
      TL_IDLE: begin
        if (emergency) state_next = TL_EMERG;
        else if (arb_valid) begin
          state_next = TL_GREEN;
          take_grant = 1'b1;
        end
      end
      TL_GREEN: begin
        green[active_dir] = 1'b1;
        if (emergency || expired) state_next = TL_YELLOW;
      end
      TL_YELLOW: begin
        yellow[active_dir] = 1'b1;
        if (expired) state_next = TL_CLEAR;
      end
      TL_CLEAR: begin
        if (emergency) state_next = TL_EMERG;
        else if (expired) begin
          if (arb_valid) begin
            state_next = TL_GREEN;
            take_grant = 1'b1;
          end else begin
            state_next = TL_IDLE;
          end
        end
      end
      TL_EMERG: begin
        if (!emergency) state_next = TL_CLEAR;
      end
      default: state_next = TL_IDLE;
    endcase
    red = ~(green | yellow);
  end

  // Dwell length for the state about to be entered.
  always_comb begin
    case (state_next)
      TL_GREEN:  timer_load = TMR_W'(GREEN_TICKS - 1);
      TL_YELLOW: timer_load = TMR_W'(YELLOW_TICKS - 1);
      TL_CLEAR:  timer_load = TMR_W'(CLEAR_TICKS - 1);
      default:   timer_load = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= TL_IDLE;
    else       state <= state_next;
  end

  // Request latching, service bookkeeping and phase timing.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending     <= '0;
      active_dir  <= '0;
      last_served <= DIR_W'(N_DIR - 1);
      timer       <= '0;
      prescaler   <= '0;
    end else begin
      // The direction being granted drops its request even if its car is
      // still high; other directions keep accumulating.
      if (take_grant) begin
        pending     <= (pending | car) & ~(N_DIR'(1) << arb_grant);
        active_dir  <= arb_grant;
        last_served <= arb_grant;
      end else begin
        pending <= pending | car;
      end
      if (state_next != state) begin
        timer     <= timer_load;
        prescaler <= '0;
      end else begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
        if (tick && timer != '0) timer <= timer - TMR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_intersection.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_intersection
//  Description : Directed vector table plus multi-cycle service-order and
//                phase-length sequences for traffic_light_intersection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_intersection;

  logic       clock;
  logic       reset, emergency;
  logic [3:0] car;
  logic [3:0] red, yellow, green;
  logic [1:0] active_dir;

  logic       reset4, emergency4;
  logic [3:0] car4;
  logic [3:0] red4, yellow4, green4;
  logic [1:0] active_dir4;

  int n_vec = 0;
  int n_bad = 0;

  traffic_light_intersection #(.N_DIR(4), .TICK_DIV(1)) dut (
    .clock(clock), .reset(reset), .car(car), .emergency(emergency),
    .red(red), .yellow(yellow), .green(green), .active_dir(active_dir)
  );

  traffic_light_intersection #(.N_DIR(4), .TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset4), .car(car4), .emergency(emergency4),
    .red(red4), .yellow(yellow4), .green(green4), .active_dir(active_dir4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] car;
    logic       em;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] ad;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] c, input logic em,
                              input logic [3:0] g, input logic [3:0] y,
                              input logic [1:0] ad, input int n);
    vec_t v;
    v.rst = rst; v.car = c; v.em = em; v.g = g; v.y = y; v.ad = ad;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] g_of(input bit w);
    return w ? green4 : green;
  endfunction
  function automatic logic [3:0] y_of(input bit w);
    return w ? yellow4 : yellow;
  endfunction
  function automatic logic [1:0] ad_of(input bit w);
    return w ? active_dir4 : active_dir;
  endfunction

  // Lamp invariants on both instances every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      n_vec++;
      if (red !== ~(green | yellow) || $countones(green | yellow) > 1) begin
        n_bad++;
        $display("FAIL invariant dut: red=%b green=%b yellow=%b, required red=~(g|y), <=1 lit", red, green, yellow);
      end
    end
    if (!reset4) begin
      n_vec++;
      if (red4 !== ~(green4 | yellow4) || $countones(green4 | yellow4) > 1) begin
        n_bad++;
        $display("FAIL invariant dut4: red=%b green=%b yellow=%b, required red=~(g|y), <=1 lit", red4, green4, yellow4);
      end
    end
  end

  // Wait for a green phase of exp_dir, then measure green/yellow/clear lengths.
  task automatic serve(input bit w, input int dir, input int gn, input int yn, input int cn);
    logic [3:0] oh;
    int cnt;
    oh  = 4'b0001 << dir;
    cnt = 0;
    while (g_of(w) == 4'b0000 && cnt < 400) begin step(); cnt++; end
    n_vec++;
    if (g_of(w) !== oh || ad_of(w) !== 2'(dir)) begin
      n_bad++;
      $display("FAIL serve%0d order: green=%b dir=%0d, required green=%b dir=%0d", w, g_of(w), ad_of(w), oh, dir);
    end
    cnt = 0;
    while (g_of(w) == oh && cnt < 400) begin step(); cnt++; end
    n_vec++;
    if (cnt != gn) begin
      n_bad++;
      $display("FAIL serve%0d green_len dir%0d: got %0d, required %0d", w, dir, cnt, gn);
    end
    cnt = 0;
    while (y_of(w) == oh && cnt < 400) begin step(); cnt++; end
    n_vec++;
    if (cnt != yn) begin
      n_bad++;
      $display("FAIL serve%0d yellow_len dir%0d: got %0d, required %0d", w, dir, cnt, yn);
    end
    cnt = 0;
    while (g_of(w) == 4'b0000 && y_of(w) == 4'b0000 && cnt < 400) begin step(); cnt++; end
    n_vec++;
    if (cnt != cn) begin
      n_bad++;
      $display("FAIL serve%0d clear_len dir%0d: got %0d, required %0d", w, dir, cnt, cn);
    end
  endtask

  initial begin
    reset = 1'b1; car = '0; emergency = 1'b0;
    reset4 = 1'b1; car4 = '0; emergency4 = 1'b0;

    // car[2] single pulse from reset
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 2);
    add(0, 4'b0100, 0, 4'b0100, 4'b0000, 2'd2, 1);
    add(0, 4'b0000, 0, 4'b0100, 4'b0000, 2'd2, 7);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100, 2'd2, 3);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd2, 4);
    // emergency during third green cycle of dir 1, car[3] latched in EMERG
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 2'd1, 1);
    add(0, 4'b0000, 0, 4'b0010, 4'b0000, 2'd1, 2);
    add(0, 4'b0000, 1, 4'b0000, 4'b0010, 2'd1, 3);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 2'd1, 2);
    add(0, 4'b1000, 1, 4'b0000, 4'b0000, 2'd1, 1);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 2'd1, 3);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd1, 2);
    add(0, 4'b0000, 0, 4'b1000, 4'b0000, 2'd3, 8);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 2'd3, 3);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd3, 3);
    // car[0] and emergency together in IDLE
    add(0, 4'b0001, 1, 4'b0000, 4'b0000, 2'd3, 1);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 2'd3, 2);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd3, 2);
    add(0, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0, 8);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001, 2'd0, 3);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 3);
    // reset mid-yellow discards pending[2]
    add(0, 4'b0010, 0, 4'b0010, 4'b0000, 2'd1, 1);
    add(0, 4'b0100, 0, 4'b0010, 4'b0000, 2'd1, 1);
    add(0, 4'b0000, 0, 4'b0010, 4'b0000, 2'd1, 6);
    add(0, 4'b0000, 0, 4'b0000, 4'b0010, 2'd1, 1);
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; car = vecs[i].car; emergency = vecs[i].em;
      step();
      n_vec++;
      if (red !== ~(vecs[i].g | vecs[i].y) || yellow !== vecs[i].y ||
          green !== vecs[i].g || active_dir !== vecs[i].ad) begin
        n_bad++;
        $display("FAIL vec%0d: red=%b yellow=%b green=%b dir=%0d, required red=%b yellow=%b green=%b dir=%0d",
                 i, red, yellow, green, active_dir,
                 ~(vecs[i].g | vecs[i].y), vecs[i].y, vecs[i].g, vecs[i].ad);
      end
    end

    // car=1011 held: round-robin order 0,1,3 repeating
    car = 4'b1011;
    serve(0, 0, 8, 3, 2);
    serve(0, 1, 8, 3, 2);
    serve(0, 3, 8, 3, 2);
    serve(0, 0, 8, 3, 2);
    serve(0, 1, 8, 3, 2);
    serve(0, 3, 8, 3, 2);
    car = 4'b0000;

    // TICK_DIV=4: every direction gets 32/12/8 cycles
    step();
    reset4 = 1'b0;
    car4   = 4'b1111;
    serve(1, 0, 32, 12, 8);
    serve(1, 1, 32, 12, 8);
    serve(1, 2, 32, 12, 8);
    serve(1, 3, 32, 12, 8);
    car4 = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
